// File: rtl/cic_comb.sv
// CIC comb section: N cascaded y[n] = x[n] - x[n-M] stages that advance only on
// the decimated sample strobe, one register per stage, modular arithmetic.
module cic_comb #(
    parameter int WIDTH      = 16,
    parameter int N_STAGES   = 3,
    parameter int DIFF_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic signed [WIDTH-1:0] out,
    output logic                    out_valid
);

    // Growth is budgeted upstream, so the difference simply wraps.
    function automatic logic signed [WIDTH-1:0] wrap_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        return a - b;
    endfunction

    logic signed [WIDTH-1:0] x_s [N_STAGES+1];
    logic [N_STAGES:0]       v_s;

    assign x_s[0] = in;
    assign v_s[0] = in_valid;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic signed [WIDTH-1:0] dly_q [DIFF_DELAY];
        logic signed [WIDTH-1:0] stg_q;
        logic signed [WIDTH-1:0] stg_d;
        logic                    vld_q;

        always_comb stg_d = wrap_sub(x_s[k], dly_q[DIFF_DELAY-1]);

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < DIFF_DELAY; i++) dly_q[i] <= '0;
                stg_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= v_s[k];
                if (v_s[k]) begin
                    stg_q    <= stg_d;
                    dly_q[0] <= x_s[k];
                    for (int i = 1; i < DIFF_DELAY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign x_s[k+1] = stg_q;
        assign v_s[k+1] = vld_q;
    end

    assign out       = x_s[N_STAGES];
    assign out_valid = v_s[N_STAGES];

endmodule

// File: tb/tb_cic_comb.sv
// Scoreboard bench for cic_comb: three configurations driven with directed
// vectors; monitors pop hand-computed expectations on every out_valid pulse.
module tb_cic_comb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic signed [15:0] d3_in, d1_in, d2_in;
    logic signed [15:0] d3_out, d1_out, d2_out;
    logic               d3_iv, d1_iv, d2_iv;
    logic               d3_ov, d1_ov, d2_ov;

    cic_comb #(.WIDTH(16), .N_STAGES(3), .DIFF_DELAY(1)) u_d3 (
        .clk(clk), .rstn(rstn), .in(d3_in), .in_valid(d3_iv),
        .out(d3_out), .out_valid(d3_ov));
    cic_comb #(.WIDTH(16), .N_STAGES(1), .DIFF_DELAY(1)) u_d1 (
        .clk(clk), .rstn(rstn), .in(d1_in), .in_valid(d1_iv),
        .out(d1_out), .out_valid(d1_ov));
    cic_comb #(.WIDTH(16), .N_STAGES(1), .DIFF_DELAY(2)) u_d2 (
        .clk(clk), .rstn(rstn), .in(d2_in), .in_valid(d2_iv),
        .out(d2_out), .out_valid(d2_ov));

    int checks = 0;
    int errors = 0;
    logic [15:0] q3[$], q1[$], q2[$];
    logic [15:0] prev3 = '0, prev1 = '0, prev2 = '0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitors: pop on out_valid, otherwise out must hold its value.
    always @(negedge clk) begin
        if (!rstn) chk("d3_valid_in_reset", {15'd0, d3_ov}, 16'd0);
        else if (d3_ov) begin
            if (q3.size() == 0) chk("d3_unexpected_valid", d3_out, 16'hxxxx);
            else chk("d3_out", d3_out, q3.pop_front());
        end else chk("d3_hold", d3_out, prev3);
        prev3 = d3_out;
    end

    always @(negedge clk) begin
        if (!rstn) chk("d1_valid_in_reset", {15'd0, d1_ov}, 16'd0);
        else if (d1_ov) begin
            if (q1.size() == 0) chk("d1_unexpected_valid", d1_out, 16'hxxxx);
            else chk("d1_out", d1_out, q1.pop_front());
        end else chk("d1_hold", d1_out, prev1);
        prev1 = d1_out;
    end

    always @(negedge clk) begin
        if (!rstn) chk("d2_valid_in_reset", {15'd0, d2_ov}, 16'd0);
        else if (d2_ov) begin
            if (q2.size() == 0) chk("d2_unexpected_valid", d2_out, 16'hxxxx);
            else chk("d2_out", d2_out, q2.pop_front());
        end else chk("d2_hold", d2_out, prev2);
        prev2 = d2_out;
    end

    // Called just after a negedge; strobe lasts one cycle, then gap idle cycles.
    task automatic send(input int sel, input logic [15:0] x, input logic [15:0] e, input int gap);
        case (sel)
            3: begin d3_in = x; d3_iv = 1'b1; q3.push_back(e); end
            1: begin d1_in = x; d1_iv = 1'b1; q1.push_back(e); end
            default: begin d2_in = x; d2_iv = 1'b1; q2.push_back(e); end
        endcase
        @(negedge clk);
        d3_iv = 1'b0; d1_iv = 1'b0; d2_iv = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rstn = 1'b0;
        q3.delete(); q1.delete(); q2.delete();
        #1;
        chk("rst_d3_out", d3_out, 16'h0000);
        chk("rst_d3_valid", {15'd0, d3_ov}, 16'd0);
        chk("rst_d1_out", d1_out, 16'h0000);
        chk("rst_d2_out", d2_out, 16'h0000);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
    endtask

    logic [15:0] imp_in  [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] imp_out [5] = '{16'h0001, 16'hFFFD, 16'h0003, 16'hFFFF, 16'h0000};
    logic [15:0] stp_out [6] = '{16'h0005, 16'hFFF6, 16'h0005, 16'h0000, 16'h0000, 16'h0000};

    initial begin
        rstn = 1'b0;
        d3_in = '0; d1_in = '0; d2_in = '0;
        d3_iv = 1'b0; d1_iv = 1'b0; d2_iv = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_d3_out", d3_out, 16'h0000);
        chk("init_d3_valid", {15'd0, d3_ov}, 16'd0);
        chk("init_d1_valid", {15'd0, d1_ov}, 16'd0);
        chk("init_d2_valid", {15'd0, d2_ov}, 16'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);

        // Wrap-around (N=1, M=1) and differential delay 2 (N=1, M=2)
        send(1, 16'hFFFF, 16'hFFFF, 0);
        send(1, 16'h0001, 16'h0002, 2);
        send(2, 16'd3, 16'd3, 0);
        send(2, 16'd7, 16'd7, 0);
        send(2, 16'd10, 16'd7, 4);

        // Impulse back-to-back, then every 4 cycles
        for (int i = 0; i < 5; i++) send(3, imp_in[i], imp_out[i], 0);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) send(3, imp_in[i], imp_out[i], 3);
        repeat (6) @(negedge clk);

        // Step, history is clean after the impulses
        for (int i = 0; i < 6; i++) send(3, 16'd5, stp_out[i], 0);
        repeat (6) @(negedge clk);

        // Clear history, then step interrupted by reset between strobes 2 and 3
        pulse_reset();
        send(3, 16'd5, 16'h0005, 3);
        send(3, 16'd5, 16'hFFF6, 0);
        pulse_reset();
        send(3, 16'd5, 16'h0005, 0);
        repeat (10) @(negedge clk);

        chk("d3_drained", 16'(q3.size()), 16'd0);
        chk("d1_drained", 16'(q1.size()), 16'd0);
        chk("d2_drained", 16'(q2.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_comb.md
Name: cic_comb

Overview:
- N-stage CIC comb section that sits directly downstream of the decimator and consumes its rate-reduced samples.
- Runs on the fast clock and advances only on a one-cycle sample strobe (the decimator's slow-rate tick, qualified to one clk cycle).
- Computes y[n] = x[n] - x[n-M] per stage, in modular two's-complement arithmetic, completing the CIC transfer function.
- Fully pipelined: one register per stage.

Parameters:
- WIDTH, 16: sample width in bits. Input, all internal registers and output share this width. CIC register growth is already accounted for upstream.
- N_STAGES, 3: number of cascaded comb stages; legal range 1..8.
- DIFF_DELAY, 1: differential delay M in samples; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- in  input  WIDTH  decimated sample from the decimator; sampled only when in_valid=1.
- in_valid  input  1  one-clk-cycle strobe, one per decimated sample; back-to-back (every cycle) is legal.
- out  output  WIDTH  comb result; held stable between updates.
- out_valid  output  1  one-cycle strobe marking a new value on out.

Behaviour:
- Clocking and reset (already decided): single clock clk; reset rstn is asynchronous, active-low.
- While rstn=0, all of the following are 0 immediately and stay 0:
  - every delay-line entry, every stage output register and stage valid bit;
  - out and out_valid.
- Stage k (k=0..N_STAGES-1):
  - Input x_k is `in` for k=0, otherwise stage k-1's registered output. Valid v_k is in_valid for k=0, otherwise stage k-1's registered valid.
  - On a clk edge with v_k=1:
    - stage output register <= x_k - d_k[M-1], truncated to WIDTH bits (mod 2^WIDTH, no saturation);
    - delay line shifts: d_k[0] <= x_k, d_k[i] <= d_k[i-1];
    - stage valid register <= 1.
  - With v_k=0: the delay line and output register hold, and the stage valid register <= 0.
- Latency: in_valid at edge t produces out_valid=1 for exactly one cycle after edge t+N_STAGES-1, i.e. N_STAGES register stages.
- out equals the last stage's output register and remains unchanged between out_valid pulses.
- The sample sequence on out is independent of in_valid spacing: every cycle, every DEC_RATE cycles, or irregular gaps all give the same sequence.
- History after reset is zero:
  - the first M samples after reset are differenced against 0;
  - an impulse response therefore starts cleanly.
- Reset mid-operation:
  - samples in flight are discarded and no out_valid is produced for them;
  - the first in_valid after rstn rises is treated as the first sample.
- No backpressure: the block is always ready; a valid presented in every cycle is accepted in every cycle.
- Assertion-level properties the verification engineer must check:
  - out is stable whenever out_valid=0;
  - out_valid is never high during reset, nor in the first N_STAGES cycles after rstn rises;
  - the number of out_valid pulses equals the number of in_valid pulses, once the pipeline has drained and no reset has occurred.

Test Plan:
- Impulse (WIDTH=16, N_STAGES=3, M=1): in = 1, 0, 0, 0, 0 on successive strobes -> out = 0x0001, 0xFFFD, 0x0003, 0xFFFF, 0x0000; first out_valid 3 cycles after the first in_valid.
- Step (N_STAGES=3, M=1): constant in=5 for 6 strobes -> out = 0x0005, 0xFFF6, 0x0005, 0x0000, 0x0000, 0x0000.
- Wrap-around (N_STAGES=1, M=1): in = 0xFFFF then 0x0001 -> out = 0xFFFF then 0x0002, with no saturation. Also M=2, in = 3, 7, 10 -> out = 3, 7, 7.
- Strobe spacing: repeat the impulse once with in_valid every cycle and once every 4 cycles -> identical out sequences; out held stable for the 3 idle cycles between pulses.
- Reset mid-stream:
  - drive the step test, then pull rstn low between strobes 2 and 3 -> out=0 and out_valid=0 immediately;
  - after release, in=5 -> first output is 0x0005, confirming history was cleared;
  - no stale out_valid appears.
